// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
//   fetch_state_e : RUN (issuing ROM reads) / FAULT (fetch PC unusable, no issue)
//   INSTR_W       : instruction word width
//   WORD_BYTES    : PC increment per fetched word
//   pc_ok()       : 1 when a byte PC is word aligned and inside the ROM window
package ifetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  localparam int INSTR_W    = 32;
  localparam int WORD_BYTES = 4;

  // Fetchable byte range is [0, 2^(addr_w+2)); anything above, or a PC
  // that is not word aligned, must never reach the ROM.
  function automatic logic pc_ok(input logic [31:0] pc, input int addr_w);
    return (pc[1:0] == 2'b00) && ((pc >> (addr_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: synchronous FIFO with synchronous flush and show-ahead head.
//   clock, reset : clock, asynchronous active-high reset
//   flush        : empties the queue this cycle (wins over push/pop)
//   push, push_data : write one entry at the tail (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   head_data    : entry at the head (meaningless while empty)
//   count, full, empty : occupancy status, all registered
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int WIDTH = 2 * INSTR_W,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = mem[rd_ptr_q];

  // NOTE: the storage array has no reset; entries are only observable once
  // written, and leaving it out of reset keeps it a plain register file/RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a
// synchronous ROM (data one cycle after the strobe), queues returned words
// with their PCs and hands them to decode over valid/ready.
//   clock, reset           : clock, asynchronous active-high reset
//   rom_en_o, rom_adr_o    : ROM read strobe and word address
//   rom_data_i             : ROM read data, one cycle after rom_en_o
//   redirect_i/_pc_i       : execute-stage redirect; flushes queue and in-flight read
//   instr_valid_o/ready_i  : decode handshake
//   instr_o, instr_pc_o    : head instruction and its byte PC
//   link_addr_o            : instr_pc_o + 4
//   fetch_fault_o          : high while fetch is stopped on a bad PC
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               rom_en_o,
  output logic [ADDR_W-1:0]  rom_adr_o,
  input  logic [INSTR_W-1:0] rom_data_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        instr_pc_o,
  output logic [31:0]        link_addr_o,
  output logic               fetch_fault_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e       state_q;
  logic [31:0]        fetch_pc_q;
  logic [31:0]        pc_next;
  logic               epoch_q;
  logic               inflight_q;
  logic               tag_q;
  logic [31:0]        req_pc_q;
  logic [INSTR_W-1:0] last_instr_q;
  logic [31:0]        last_pc_q;
  logic [31:0]        last_link_q;

  logic               issue;
  logic               credit_ok;
  logic [CNT_W:0]     credit_used;
  logic               push;
  logic               pop;
  logic [63:0]        head_data;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [31:0]        head_pc;
  logic [INSTR_W-1:0] head_instr;

  // The in-flight read already owns a queue slot, so the queue can never overflow.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok   = (credit_used < (CNT_W + 1)'(DEPTH)) && !fifo_full;
  assign issue       = (state_q == RUN) && !redirect_i && credit_ok && pc_ok(fetch_pc_q, ADDR_W);

  assign rom_en_o  = issue && !reset;
  assign rom_adr_o = fetch_pc_q[ADDR_W+1:2];

  // A response belongs to the current stream only if no redirect happened since its issue.
  assign push = inflight_q && (tag_q == epoch_q);
  assign pop  = instr_valid_o && instr_ready_i;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pc_next = fetch_pc_q;
    if (redirect_i)  pc_next = redirect_pc_i;
    else if (issue)  pc_next = fetch_pc_q + 32'(WORD_BYTES);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      epoch_q      <= 1'b0;
      inflight_q   <= 1'b0;
      tag_q        <= 1'b0;
      req_pc_q     <= '0;
      last_instr_q <= '0;
      last_pc_q    <= '0;
      last_link_q  <= '0;
    end else begin
      fetch_pc_q <= pc_next;
      inflight_q <= issue;
      if (issue) begin
        tag_q    <= epoch_q;
        req_pc_q <= fetch_pc_q;
      end
      if (redirect_i) epoch_q <= ~epoch_q;

      // Fault is decided on the PC that will be presented next cycle, so a
      // bad redirect target shows up as FAULT one cycle after the redirect.
      if (state_q == RUN) begin
        if (!pc_ok(pc_next, ADDR_W)) state_q <= FAULT;
      end else if (redirect_i && pc_ok(redirect_pc_i, ADDR_W)) begin
        state_q <= RUN;
      end

      // Remember the last presented head so outputs hold while the queue is empty.
      if (!fifo_empty) begin
        last_instr_q <= head_instr;
        last_pc_q    <= head_pc;
        last_link_q  <= head_pc + 32'd4;
      end
    end
  end

  ifetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (push),
    .push_data ({req_pc_q, rom_data_i}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_pc    = head_data[63:32];
  assign head_instr = head_data[31:0];

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? last_instr_q : head_instr;
  assign instr_pc_o    = fifo_empty ? last_pc_q    : head_pc;
  assign link_addr_o   = fifo_empty ? last_link_q  : head_pc + 32'd4;
  assign fetch_fault_o = (state_q == FAULT);

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch. The ROM model returns its word address
// as data, so every delivered instruction must equal instr_pc_o >> 2.
module tb_ifetch_prefetch;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_adr_o;
  logic [31:0]       rom_data_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [31:0]       instr_o;
  logic [31:0]       instr_pc_o;
  logic [31:0]       link_addr_o;
  logic              fetch_fault_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_iss;

  always #5 clock = ~clock;

  ifetch_prefetch #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_en_o      (rom_en_o),
    .rom_adr_o     (rom_adr_o),
    .rom_data_i    (rom_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .link_addr_o   (link_addr_o),
    .fetch_fault_o (fetch_fault_o)
  );

  // Synchronous ROM: ROM[i] = i.
  always @(posedge clock) begin
    if (rom_en_o) rom_data_i <= 32'(rom_adr_o);
  end

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_bit ({tag, ".valid"}, instr_valid_o, 1'b1);
    check_word({tag, ".pc"},    instr_pc_o,    pc);
    check_word({tag, ".instr"}, instr_o,       pc >> 2);
    check_word({tag, ".link"},  link_addr_o,   pc + 32'd4);
  endtask

  // Leaves time 2 units after a rising edge: the new cycle's state is visible.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic next_cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    step();
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  // Ends inside cycle 0, the first cycle with reset released.
  task automatic apply_reset();
    step();
    reset         = 1'b1;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    #1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    rom_data_i    = 32'h0;

    // Reset state
    repeat (3) step();
    #1;
    check_bit ("rst.rom_en", rom_en_o,      1'b0);
    check_word("rst.rom_adr", 32'(rom_adr_o), 32'h0);
    check_bit ("rst.valid",  instr_valid_o, 1'b0);
    check_bit ("rst.fault",  fetch_fault_o, 1'b0);
    check_word("rst.instr",  instr_o,       32'h0);
    check_word("rst.pc",     instr_pc_o,    32'h0);
    check_word("rst.link",   link_addr_o,   32'h0);

    // 1: streaming from reset with ready=1
    reset         = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    check_bit ("t1.c0.rom_en",  rom_en_o, 1'b1);
    check_word("t1.c0.rom_adr", 32'(rom_adr_o), 32'h0);
    check_bit ("t1.c0.valid",   instr_valid_o, 1'b0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t1.c1.valid",   instr_valid_o, 1'b0);
    for (int k = 2; k <= 7; k++) begin
      next_cycle(1'b1, 1'b0, 32'h0);
      check_head($sformatf("t1.c%0d", k), 32'(4 * (k - 2)));
    end

    // 2: stall fills exactly DEPTH entries, then drains without gap
    apply_reset();
    n_iss = int'(rom_en_o);
    for (int k = 1; k <= 9; k++) begin
      next_cycle(1'b0, 1'b0, 32'h0);
      n_iss += int'(rom_en_o);
    end
    check_bit ("t2.full.rom_en", rom_en_o, 1'b0);
    check_word("t2.issues", 32'(n_iss), 32'(DEPTH));
    check_head("t2.stall", 32'h0);
    for (int k = 10; k <= 16; k++) begin
      next_cycle(1'b1, 1'b0, 32'h0);
      check_head($sformatf("t2.c%0d", k), 32'(4 * (k - 10)));
    end

    // 3: redirect with three queued and one read in flight
    apply_reset();
    repeat (3) next_cycle(1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b1, 32'h100);
    check_bit ("t3.t.rom_en", rom_en_o, 1'b0);
    next_cycle(1'b0, 1'b0, 32'h0);
    check_bit ("t3.t1.valid",   instr_valid_o, 1'b0);
    check_bit ("t3.t1.rom_en",  rom_en_o, 1'b1);
    check_word("t3.t1.rom_adr", 32'(rom_adr_o), 32'h40);
    next_cycle(1'b0, 1'b0, 32'h0);
    check_bit ("t3.t2.valid",   instr_valid_o, 1'b0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_head("t3.t3", 32'h100);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_head("t3.t4", 32'h104);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_head("t3.t5", 32'h108);

    // 4: misaligned redirect faults, good redirect recovers
    next_cycle(1'b1, 1'b1, 32'h102);
    check_bit ("t4.u.rom_en", rom_en_o, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle(1'b1, 1'b0, 32'h0);
      check_bit ($sformatf("t4.u%0d.fault", k),  fetch_fault_o, 1'b1);
      check_bit ($sformatf("t4.u%0d.rom_en", k), rom_en_o, 1'b0);
      check_bit ($sformatf("t4.u%0d.valid", k),  instr_valid_o, 1'b0);
    end
    next_cycle(1'b1, 1'b1, 32'h40);
    check_bit ("t4.u4.fault",  fetch_fault_o, 1'b1);
    check_bit ("t4.u4.rom_en", rom_en_o, 1'b0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t4.u5.fault",   fetch_fault_o, 1'b0);
    check_bit ("t4.u5.rom_en",  rom_en_o, 1'b1);
    check_word("t4.u5.rom_adr", 32'(rom_adr_o), 32'h10);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t4.u6.valid", instr_valid_o, 1'b0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_head("t4.u7", 32'h40);

    // 5: last word of the ROM window, then out-of-range fault
    next_cycle(1'b1, 1'b1, 32'hFFFC);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t5.v1.rom_en",  rom_en_o, 1'b1);
    check_word("t5.v1.rom_adr", 32'(rom_adr_o), 32'h3FFF);
    check_bit ("t5.v1.fault",   fetch_fault_o, 1'b0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t5.v2.fault",  fetch_fault_o, 1'b1);
    check_bit ("t5.v2.rom_en", rom_en_o, 1'b0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_head("t5.v3", 32'hFFFC);
    check_word("t5.v3.link_wrap", link_addr_o, 32'h10000);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t5.v4.valid",   instr_valid_o, 1'b0);
    check_bit ("t5.v4.fault",   fetch_fault_o, 1'b1);
    check_word("t5.v4.hold_pc", instr_pc_o, 32'hFFFC);
    check_word("t5.v4.hold_instr", instr_o, 32'h3FFF);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t5.v5.valid",  instr_valid_o, 1'b0);
    check_bit ("t5.v5.rom_en", rom_en_o, 1'b0);

    // 6: reset during a stall with a full queue
    next_cycle(1'b0, 1'b1, 32'h200);
    for (int k = 1; k <= 6; k++) next_cycle(1'b0, 1'b0, 32'h0);
    check_head("t6.full", 32'h200);
    check_bit ("t6.full.rom_en", rom_en_o, 1'b0);
    step();
    reset = 1'b1;
    #1;
    check_bit ("t6.rst.valid",  instr_valid_o, 1'b0);
    check_bit ("t6.rst.rom_en", rom_en_o, 1'b0);
    check_bit ("t6.rst.fault",  fetch_fault_o, 1'b0);
    check_word("t6.rst.instr",  instr_o, 32'h0);
    check_word("t6.rst.pc",     instr_pc_o, 32'h0);
    check_word("t6.rst.link",   link_addr_o, 32'h0);
    check_word("t6.rst.rom_adr", 32'(rom_adr_o), 32'h0);
    step();
    reset         = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    check_bit ("t6.c0.rom_en",  rom_en_o, 1'b1);
    check_word("t6.c0.rom_adr", 32'(rom_adr_o), 32'h0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_bit ("t6.c1.valid", instr_valid_o, 1'b0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_head("t6.c2", 32'h0);
    next_cycle(1'b1, 1'b0, 32'h0);
    check_head("t6.c3", 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
